narnet_core: RTL

Parametrised NAR-network inference core: a time-multiplexed single-MAC engine for one hidden tanh layer of N_HIDDEN neurons over an N_DELAY-deep input tap line, plus a linear output neuron. Sits between the sample source (valid/ready) and the prediction consumer. Reads all weights and biases from an external synchronous ROM, and tanh from an external synchronous LUT. Generalises the fixed 5-neuron / 16-tap / 8-bit predictor in width, depth, neuron count and initial tap state, and adds back-pressured input and saturating arithmetic.

---
 rtl/narnet_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/narnet_core.sv
// narnet_core: time-multiplexed NAR-network inference core.
//   One hidden tanh layer (N_HIDDEN neurons over an N_DELAY-deep tap line)
//   followed by a linear output neuron, all computed on a single MAC.
//   Weights/biases come from an external synchronous ROM and tanh from an
//   external synchronous LUT (both return data one cycle after the address).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_data  sample offer; accepted when in_ready is high
//   in_ready          core idle and able to accept a sample
//   rom_addr/rom_data weight ROM port
//   lut_addr/lut_data tanh LUT port (index = narrowed pre-activation)
//   y_valid/y_out     one-cycle result strobe, y_out held until next strobe
//
// Build option:
//   NARNET_SAT_EN  when defined, every narrowing to DATA_W clamps to the
//                  signed DATA_W range; otherwise the low DATA_W bits are kept.
//
// ROM map: b1[h] at h, W1[h][k] at N_HIDDEN+h*N_DELAY+k,
//          W2[h] at N_HIDDEN*(N_DELAY+1)+h, b2 at N_HIDDEN*(N_DELAY+2).
module narnet_core #(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 6,
  parameter int N_HIDDEN = 5,
  parameter int N_DELAY  = 16,
  parameter int ADDR_W   = 8,
  parameter int INIT_TAP = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_out
);

  localparam int ACC_W   = 2*DATA_W + $clog2(N_DELAY+1);
  localparam int TAP_W   = $clog2(N_DELAY);
  localparam int HID_W   = $clog2(N_HIDDEN+2);
  localparam int CNT_MAX = ((N_DELAY > N_HIDDEN) ? N_DELAY : N_HIDDEN) + 2;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int W1_BASE = N_HIDDEN;
  localparam int W2_BASE = N_HIDDEN*(N_DELAY+1);
  localparam int B2_ADDR = N_HIDDEN*(N_DELAY+2);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

  typedef enum logic [2:0] {IDLE, PUSH, L1, TANH, L2, OUT} state_t;

  state_t                             state;
  logic [CNT_W-1:0]                   cnt;     // phase within neuron / TANH / L2
  logic [HID_W-1:0]                   h;       // current hidden neuron in L1
  logic [ADDR_W-1:0]                  w_ptr;   // next W1 address (contiguous across neurons)
  logic [TAP_W-1:0]                   wp;      // tap write pointer
  logic [N_DELAY-1:0][DATA_W-1:0]     taps;
  logic [N_HIDDEN-1:0][DATA_W-1:0]    pre;
  logic [N_HIDDEN-1:0][DATA_W-1:0]    act;
  logic [DATA_W-1:0]                  sample;
  logic signed [ACC_W-1:0]            acc;

  // Arithmetic shift (floor) then narrow: clamp or wrap.
  function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       r;
    s = a >>> FRAC_W;
`ifdef NARNET_SAT_EN
    if (s > S_MAX)      r = S_MAX[DATA_W-1:0];
    else if (s < S_MIN) r = S_MIN[DATA_W-1:0];
    else                r = s[DATA_W-1:0];
`else
    r = s[DATA_W-1:0];
`endif
    return r;
  endfunction

  // Tap k (k = cnt-2) is the sample accepted k steps ago; newest sits at wp-1.
  logic [TAP_W-1:0] tap_idx;
  always_comb begin
    int ti;
    ti = 0;
    if (cnt >= CNT_W'(2)) begin
      ti = int'(wp) + N_DELAY + 1 - int'(cnt);
      if (ti >= N_DELAY) ti = ti - N_DELAY;
    end
    tap_idx = TAP_W'(ti);
  end

  logic [HID_W-1:0] a_idx, t_m1, t_p1;
  assign a_idx = (cnt >= CNT_W'(2)) ? HID_W'(cnt - CNT_W'(2)) : '0;
  assign t_m1  = HID_W'(cnt - CNT_W'(1));
  assign t_p1  = HID_W'(cnt + CNT_W'(1));

  // Single MAC: ROM word times tap (L1) or activation (L2).
  logic [DATA_W-1:0]         mul_b;
  logic signed [2*DATA_W-1:0] op_a, op_b, prod;
  logic signed [ACC_W-1:0]    rom_ext, bias_ext, acc_sum;

  assign mul_b    = (state == L2) ? act[a_idx] : taps[tap_idx];
  assign op_a     = {{DATA_W{rom_data[DATA_W-1]}}, rom_data};
  assign op_b     = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
  assign prod     = op_a * op_b;
  assign rom_ext  = {{(ACC_W-DATA_W){rom_data[DATA_W-1]}}, rom_data};
  assign bias_ext = rom_ext <<< FRAC_W;
  assign acc_sum  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      y_valid  <= 1'b0;
      y_out    <= '0;
      rom_addr <= '0;
      lut_addr <= '0;
      taps     <= {N_DELAY{DATA_W'(INIT_TAP)}};
      wp       <= '0;
      cnt      <= '0;
      h        <= '0;
      w_ptr    <= '0;
      acc      <= '0;
      sample   <= '0;
      pre      <= '0;
      act      <= '0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sample   <= in_data;
            in_ready <= 1'b0;
            state    <= PUSH;
          end
        end

        PUSH: begin
          taps[wp] <= sample;
          wp       <= (wp == TAP_W'(N_DELAY-1)) ? '0 : wp + TAP_W'(1);
          rom_addr <= '0;                 // b1[0]
          w_ptr    <= ADDR_W'(W1_BASE);
          h        <= '0;
          cnt      <= '0;
          state    <= L1;
        end

        // cnt 0: bias address out; 1..N_DELAY: weight addresses out;
        // data lags address by one, so the MAC runs at cnt 2..N_DELAY+1.
        L1: begin
          if (cnt == CNT_W'(1))       acc <= bias_ext;
          else if (cnt >= CNT_W'(2))  acc <= acc_sum;
          if (cnt == CNT_W'(N_DELAY+1)) begin
            pre[h] <= narrow(acc_sum);
            cnt    <= '0;
            if (h == HID_W'(N_HIDDEN-1)) begin
              state    <= TANH;
              // With one neuron its pre-activation is being written this edge.
              lut_addr <= (N_HIDDEN == 1) ? narrow(acc_sum) : pre[0];
            end else begin
              h        <= h + HID_W'(1);
              rom_addr <= ADDR_W'(h) + ADDR_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(N_DELAY)) begin
              rom_addr <= w_ptr;
              w_ptr    <= w_ptr + ADDR_W'(1);
            end
          end
        end

        // LUT index pre[t] is presented at cnt t, its result captured at t+1.
        TANH: begin
          if (cnt != '0) act[t_m1] <= lut_data;
          if (cnt == CNT_W'(N_HIDDEN)) begin
            cnt      <= '0;
            rom_addr <= ADDR_W'(B2_ADDR);
            state    <= L2;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(N_HIDDEN-1)) lut_addr <= pre[t_p1];
          end
        end

        L2: begin
          if (cnt == CNT_W'(1))       acc <= bias_ext;
          else if (cnt >= CNT_W'(2))  acc <= acc_sum;
          if (cnt == CNT_W'(N_HIDDEN+1)) begin
            y_out   <= narrow(acc_sum);
            y_valid <= 1'b1;
            cnt     <= '0;
            state   <= OUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(N_HIDDEN))
              rom_addr <= ADDR_W'(W2_BASE) + ADDR_W'(cnt);
          end
        end

        // Strobe cycle; ready returns on the following cycle.
        OUT: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
